// File: rtl/mux8_arb.sv
// mux8_arb: round-robin arbiter sharing one W-bit output channel between
// requesters A and B. The winner's data passes through the 2:1 mux and is
// captured into a one-entry output register with valid/ready on every side.
// Optional feature macro: MUX8_ARB_BURST_EN (lets the current owner keep the
// grant for up to HOLD_MAX consecutive beats while the other requester waits).
module mux8_arb #(
    parameter int W        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a_data,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] b_data,
    input  logic         b_valid,
    output logic         b_ready,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         sel,
    output logic         last
);

    // The output register is either empty or holds exactly one beat.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Out-of-range hold limits are rejected at elaboration time.
    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
        $error("mux8_arb: HOLD_MAX must be in 1..15");
    end

    state_e       state_q, state_d;
    logic [W-1:0] y_data_q, y_data_d;
    logic         last_q, last_d;
    logic         grant;
    logic         load;
    logic         xfer;
    logic [W-1:0] mux_y;

`ifdef MUX8_ARB_BURST_EN
    localparam logic [3:0] CNT_MAX = 4'(HOLD_MAX - 1);

    // served_q distinguishes "no beat since reset" from a real streak, so the
    // reset value of last_q still hands the first beat to A.
    logic [3:0] cnt_q, cnt_d;
    logic       served_q, served_d;
`endif

    // Grant selection: a lone requester always wins; contention alternates
    // (or, in burst mode, lets the current owner finish its burst).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        grant = last_q;
        unique case ({a_valid, b_valid})
            2'b10: grant = 1'b0;
            2'b01: grant = 1'b1;
`ifdef MUX8_ARB_BURST_EN
            2'b11: grant = (served_q && (cnt_q < CNT_MAX)) ? last_q : !last_q;
`else
            2'b11: grant = !last_q;
`endif
            default: grant = last_q;
        endcase
    end

    // Handshakes are forced low while reset is held.
    assign sel     = rst_n & grant;
    assign load    = rst_n & ((state_q == EMPTY) | y_ready);
    assign a_ready = load & a_valid & ~sel;
    assign b_ready = load & b_valid & sel;
    assign xfer    = a_ready | b_ready;

    // The shared 2:1 data mux steered by sel.
    assign mux_y = sel ? b_data : a_data;

    // Next-state: load on a transfer, otherwise drain or hold the beat.
    always_comb begin
        state_d  = state_q;
        y_data_d = y_data_q;
        last_d   = last_q;
        if (xfer) begin
            state_d  = FULL;
            y_data_d = mux_y;
            last_d   = sel;
        end else if (y_ready) begin
            state_d = EMPTY;
        end
    end

`ifdef MUX8_ARB_BURST_EN
    // Beat counter: counts consecutive beats to the same requester,
    // saturating at HOLD_MAX-1, and restarts on every switch.
    always_comb begin
        cnt_d    = cnt_q;
        served_d = served_q;
        if (xfer) begin
            served_d = 1'b1;
            if (served_q && (sel == last_q)) begin
                cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 4'd1 : cnt_q;
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    // Burst counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            served_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            served_q <= served_d;
        end
    end
`endif

    // Output register FSM; reset drops any held beat so nothing is replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the data register is reset too, so y_data reads 0 out of
            // reset rather than a stale beat.
            state_q  <= EMPTY;
            y_data_q <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            y_data_q <= y_data_d;
            last_q   <= last_d;
        end
    end

    assign y_valid = (state_q == FULL);
    assign y_data  = y_data_q;
    assign last    = last_q;

endmodule
